logic_unit_seq: RTL and testbench

Parametrised, multi-cycle bitwise logic unit that succeeds the fixed 32-bit combinational OR block in the ALU datapath. It supports AND/OR/XOR/NOR on WIDTH-bit operands and evaluates SLICE bits per clock, LSB slice first, under a start/busy/done handshake. It lets the multi-cycle datapath trade latency for area, and it sits beside the sequential multiplier in the ALU.

---
 rtl/logic_unit_seq_pkg.sv | 23 ++
 rtl/logic_unit_seq_if.sv | 24 ++
 rtl/logic_slice.sv | 25 ++
 rtl/logic_unit_seq.sv | 109 ++++++++++
 tb/tb_logic_unit_seq.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/logic_unit_seq_pkg.sv
// Shared definitions for the sliced logic unit: op codes, FSM state
// encodings and a small helper for sizing the slice counter.
package logic_unit_seq_pkg;

  typedef logic [1:0] op_t;

  // Operation codes, shared with the ALU control decoder.
  localparam op_t OP_AND = 2'b00;
  localparam op_t OP_OR  = 2'b01;
  localparam op_t OP_XOR = 2'b10;
  localparam op_t OP_NOR = 2'b11;

  // FSM state encodings.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Slice counter width: clog2 of the slice count, never below one bit.
  function automatic int cnt_bits(input int nsl);
    return (nsl > 1) ? $clog2(nsl) : 1;
  endfunction

endpackage

// File: rtl/logic_unit_seq_if.sv
// Request/response bundle of the sliced logic unit. The master issues
// start/op/a/b; the slave (the unit) returns busy/done/res/zero.
interface logic_unit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  busy, done, res, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, res, zero
  );
endinterface

// File: rtl/logic_slice.sv
// Combinational bitwise function on one SLICE-bit chunk. No carry, so
// each slice is independent of every other.
module logic_slice
  import logic_unit_seq_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [1:0]       op,
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  output logic [SLICE-1:0] r_s
);

  // Select the bitwise operation for this slice.
  always_comb begin
    r_s = '0;
    case (op)
      OP_AND:  r_s = a_s & b_s;
      OP_OR:   r_s = a_s | b_s;
      OP_XOR:  r_s = a_s ^ b_s;
      default: r_s = ~(a_s | b_s);
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: evaluates SLICE bits per clock, LSB slice
// first, behind a start/busy/done handshake. Operands and op are captured
// on the accepted start, so input changes during RUN are harmless.
module logic_unit_seq
  import logic_unit_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input logic             clk,
  input logic             rst_n,
  logic_unit_seq_if.slave bus
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = cnt_bits(NSL);
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_slice
      $error("logic_unit_seq: SLICE (%0d) must divide WIDTH (%0d)", SLICE, WIDTH);
    end
  endgenerate

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] res_reg;
  logic [WIDTH-1:0] res_next;
  logic             zero_reg;
  logic             busy_reg;
  logic             done_reg;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] r_s;

  // The single slice datapath is steered by the counter.
  assign a_s = a_reg[cnt_reg*SLICE +: SLICE];
  assign b_s = b_reg[cnt_reg*SLICE +: SLICE];

  logic_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .op  (op_reg),
    .a_s (a_s),
    .b_s (b_s),
    .r_s (r_s)
  );

  // Result with the current slice merged in; also feeds the zero flag.
  always_comb begin
    res_next = res_reg;
    res_next[cnt_reg*SLICE +: SLICE] = r_s;
  end

  // FSM, counter, operand and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= OP_AND;
      res_reg   <= '0;
      zero_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_RUN: begin
          res_reg <= res_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            zero_reg  <= (res_next == '0);
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        // IDLE and DONE both accept a new request; an illegal encoding
        // lands here too and recovers to IDLE.
        default: begin
          if (bus.start) begin
            a_reg     <= bus.a;
            b_reg     <= bus.b;
            op_reg    <= bus.op;
            res_reg   <= '0;
            cnt_reg   <= '0;
            zero_reg  <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= ST_RUN;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.res  = res_reg;
  assign bus.zero = zero_reg;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: a SLICE=8 instance and a SLICE=32 instance,
// table-driven vectors plus hand-written multi-cycle sequences, with a
// queue scoreboard popped on each done pulse.
module tb_logic_unit_seq;
  import logic_unit_seq_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic_unit_seq_if #(.WIDTH(W)) bus8 ();
  logic_unit_seq_if #(.WIDTH(W)) bus32 ();

  logic_unit_seq #(.WIDTH(W), .SLICE(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8.slave)
  );

  logic_unit_seq #(.WIDTH(W), .SLICE(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32.slave)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    int          acc;
  } exp_t;

  exp_t q8[$];
  exp_t q32[$];
  vec_t tbl[6];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // Scoreboard for the SLICE=8 instance.
  logic prev_done8 = 1'b0;
  exp_t e8;
  always @(negedge clk) begin
    if (bus8.done === 1'b1) begin
      chk("s8_done_pulse", {31'b0, prev_done8}, 32'd0);
      chk("s8_busy_in_done", {31'b0, bus8.busy}, 32'd0);
      if (q8.size() == 0) begin
        chk("s8_unexpected_done", {31'b0, bus8.done}, 32'd0);
      end else begin
        e8 = q8.pop_front();
        chk("s8_res", bus8.res, e8.res);
        chk("s8_zero", {31'b0, bus8.zero}, {31'b0, e8.zero});
        chk("s8_latency", cyc - e8.acc, 32'd4);
        $display("[cyc %0d] s8 done res=%h zero=%b", cyc, bus8.res, bus8.zero);
      end
    end
    prev_done8 <= bus8.done;
  end

  // Scoreboard for the SLICE=32 instance.
  logic prev_done32 = 1'b0;
  exp_t e32;
  always @(negedge clk) begin
    if (bus32.done === 1'b1) begin
      chk("s32_done_pulse", {31'b0, prev_done32}, 32'd0);
      if (q32.size() == 0) begin
        chk("s32_unexpected_done", {31'b0, bus32.done}, 32'd0);
      end else begin
        e32 = q32.pop_front();
        chk("s32_res", bus32.res, e32.res);
        chk("s32_zero", {31'b0, bus32.zero}, {31'b0, e32.zero});
        chk("s32_latency", cyc - e32.acc, 32'd1);
        $display("[cyc %0d] s32 done res=%h zero=%b", cyc, bus32.res, bus32.zero);
      end
    end
    prev_done32 <= bus32.done;
  end

  // Drive one start pulse on the SLICE=8 unit (called at a negedge).
  task automatic issue8(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic zero);
    bus8.start = 1'b1;
    bus8.op    = op;
    bus8.a     = a;
    bus8.b     = b;
    q8.push_back('{res, zero, cyc + 1});
    @(negedge clk);
    bus8.start = 1'b0;
    chk("s8_busy_after_start", {31'b0, bus8.busy}, 32'd1);
  endtask

  task automatic issue32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic zero);
    bus32.start = 1'b1;
    bus32.op    = op;
    bus32.a     = a;
    bus32.b     = b;
    q32.push_back('{res, zero, cyc + 1});
    @(negedge clk);
    bus32.start = 1'b0;
  endtask

  task automatic drain8();
    for (int i = 0; i < 50 && q8.size() != 0; i++) @(negedge clk);
    if (q8.size() != 0) begin
      chk("s8_timeout", q8.size(), 32'd0);
      q8.delete();
    end
  endtask

  task automatic drain32();
    for (int i = 0; i < 50 && q32.size() != 0; i++) @(negedge clk);
    if (q32.size() != 0) begin
      chk("s32_timeout", q32.size(), 32'd0);
      q32.delete();
    end
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] rr;

    tbl[0] = '{OP_OR,  32'h9000000A, 32'h1000001E, 32'h9000001E, 1'b0};
    tbl[1] = '{OP_AND, 32'h9000000A, 32'h1000001E, 32'h1000000A, 1'b0};
    tbl[2] = '{OP_XOR, 32'h9000000A, 32'h1000001E, 32'h80000014, 1'b0};
    tbl[3] = '{OP_NOR, 32'hF0E0060A, 32'h1000FC1F, 32'h0F1F01E0, 1'b0};
    tbl[4] = '{OP_AND, 32'hFFFF0000, 32'h0000FFFF, 32'h00000000, 1'b1};
    tbl[5] = '{OP_NOR, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};

    rst_n = 1'b0;
    bus8.start = 1'b0;  bus8.op = 2'b00;  bus8.a = '0;  bus8.b = '0;
    bus32.start = 1'b0; bus32.op = 2'b00; bus32.a = '0; bus32.b = '0;

    // Reset for two cycles, then check idle outputs.
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'b0, bus8.busy}, 32'd0);
    chk("rst_done", {31'b0, bus8.done}, 32'd0);
    chk("rst_res", bus8.res, 32'd0);
    chk("rst_zero", {31'b0, bus8.zero}, 32'd0);
    chk("rst32_res", bus32.res, 32'd0);
    chk("rst32_busy", {31'b0, bus32.busy}, 32'd0);
    $display("[cyc %0d] reset released", cyc);

    // OR, then res must hold after done.
    issue8(tbl[0].op, tbl[0].a, tbl[0].b, tbl[0].res, tbl[0].zero);
    drain8();
    repeat (3) @(negedge clk);
    chk("s8_res_hold", bus8.res, 32'h9000001E);
    chk("s8_zero_hold", {31'b0, bus8.zero}, 32'd0);

    // Table sweep.
    for (int i = 0; i < 6; i++) begin
      issue8(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].zero);
      drain8();
    end

    // Back-to-back: AND, with XOR presented in the DONE cycle (start held).
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.op = OP_AND; bus8.a = 32'h9000000A; bus8.b = 32'h1000001E;
    q8.push_back('{32'h1000000A, 1'b0, cyc + 1});
    q8.push_back('{32'h80000014, 1'b0, cyc + 6});
    @(negedge clk);
    bus8.op = OP_XOR;
    repeat (5) @(negedge clk);
    bus8.start = 1'b0;
    drain8();

    // Start and operand changes while busy are ignored.
    @(negedge clk);
    issue8(OP_OR, 32'h9000000A, 32'h1000001E, 32'h9000001E, 1'b0);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 32'hFFFFFFFF;
    @(negedge clk);
    bus8.start = 1'b0;
    drain8();
    repeat (3) @(negedge clk);

    // Reset in cycle 2 of RUN: no done may follow.
    issue8(OP_OR, 32'h9000000A, 32'h1000001E, 32'h9000001E, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    q8.delete();
    @(negedge clk);
    chk("midrst_busy", {31'b0, bus8.busy}, 32'd0);
    chk("midrst_res", bus8.res, 32'd0);
    chk("midrst_done", {31'b0, bus8.done}, 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_res_after", bus8.res, 32'd0);
    $display("[cyc %0d] mid-run reset checked", cyc);

    // Random vectors against the word-level model.
    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      rr = model(rop, ra, rb);
      issue8(rop, ra, rb, rr, rr == 32'd0);
      drain8();
    end

    // Single-cycle build: same table, plus randoms.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      issue32(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].zero);
      drain32();
    end
    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      rr = model(rop, ra, rb);
      issue32(rop, ra, rb, rr, rr == 32'd0);
      drain32();
    end
    repeat (3) @(negedge clk);
    chk("s32_res_hold", bus32.res, rr);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
